// File: rtl/pipeline_stage_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_regs_pkg
// Purpose  : Shared widths, constants and packed field bundles for the
//            IF/ID, ID/EX and EX/MEM pipeline registers of the RV32 core.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_stage_regs_pkg;

    localparam int          XLEN      = 32;
    localparam int          REG_AW    = 5;
    localparam int          OPC_W     = 7;
    localparam int          IID_W     = 6;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [5:0]  IID_NONE  = 6'd0;            // "no operation" id

    // Field bundle held in the ID/EX register
    typedef struct packed {
        logic              rs1_valid;
        logic              rs2_valid;
        logic              rd_valid;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_value;
        logic [XLEN-1:0]   rs2_value;
        logic [OPC_W-1:0]  opcode;
        logic [IID_W-1:0]  instr_id;
    } id_ex_t;

    // Field bundle held in the EX/MEM register
    typedef struct packed {
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rs1_value;
        logic [XLEN-1:0]   rs2_value;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN-1:0]   exec_output;
        logic [XLEN-1:0]   jump_addr;
        logic              jump_signal;
        logic              rd_valid;
        logic [IID_W-1:0]  instr_id;
    } ex_mem_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_stage_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_regs_if
// Purpose  : Bundles every stage-facing signal of the pipeline register bank.
//            slave  : view of the register bank (captures *_in, drives *_out)
//            master : view of the surrounding stage logic
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_stage_regs_if;
    import pipeline_stage_regs_pkg::*;

    // IF/ID
    logic [XLEN-1:0]   if_pc_in, if_instr_in;
    logic              if_id_stall, if_id_flush;
    logic [XLEN-1:0]   if_id_pc_out, if_id_instr_out;

    // ID/EX
    logic              id_rs1_valid_in, id_rs2_valid_in, id_rd_valid_in;
    logic [REG_AW-1:0] id_rs1_addr_in, id_rs2_addr_in, id_rd_addr_in;
    logic [XLEN-1:0]   id_imm_in, id_pc_in, id_rs1_value_in, id_rs2_value_in;
    logic [OPC_W-1:0]  id_opcode_in;
    logic [IID_W-1:0]  id_instr_id_in;
    logic              id_ex_bubble;
    logic              ex_rs1_valid_out, ex_rs2_valid_out, ex_rd_valid_out;
    logic [REG_AW-1:0] ex_rs1_addr_out, ex_rs2_addr_out, ex_rd_addr_out;
    logic [XLEN-1:0]   ex_imm_out, ex_pc_out, ex_rs1_value_out, ex_rs2_value_out;
    logic [OPC_W-1:0]  ex_opcode_out;
    logic [IID_W-1:0]  ex_instr_id_out;

    // EX/MEM
    logic [REG_AW-1:0] ex_rs1_addr_in, ex_rs2_addr_in, ex_rd_addr_in;
    logic [XLEN-1:0]   ex_rs1_value_in, ex_rs2_value_in, ex_pc_in;
    logic [XLEN-1:0]   ex_mem_addr_in, ex_exec_output_in, ex_jump_addr_in;
    logic              ex_jump_signal_in, ex_rd_valid_in;
    logic [IID_W-1:0]  ex_instr_id_in;
    logic [REG_AW-1:0] mem_rs1_addr_out, mem_rs2_addr_out, mem_rd_addr_out;
    logic [XLEN-1:0]   mem_rs1_value_out, mem_rs2_value_out, mem_pc_out;
    logic [XLEN-1:0]   mem_mem_addr_out, mem_exec_output_out, mem_jump_addr_out;
    logic              mem_jump_signal_out, mem_rd_valid_out;
    logic [IID_W-1:0]  mem_instr_id_out;

    modport slave (
        input  if_pc_in, if_instr_in, if_id_stall, if_id_flush,
        output if_id_pc_out, if_id_instr_out,
        input  id_rs1_valid_in, id_rs2_valid_in, id_rd_valid_in,
               id_rs1_addr_in, id_rs2_addr_in, id_rd_addr_in,
               id_imm_in, id_pc_in, id_rs1_value_in, id_rs2_value_in,
               id_opcode_in, id_instr_id_in, id_ex_bubble,
        output ex_rs1_valid_out, ex_rs2_valid_out, ex_rd_valid_out,
               ex_rs1_addr_out, ex_rs2_addr_out, ex_rd_addr_out,
               ex_imm_out, ex_pc_out, ex_rs1_value_out, ex_rs2_value_out,
               ex_opcode_out, ex_instr_id_out,
        input  ex_rs1_addr_in, ex_rs2_addr_in, ex_rd_addr_in,
               ex_rs1_value_in, ex_rs2_value_in, ex_pc_in,
               ex_mem_addr_in, ex_exec_output_in, ex_jump_addr_in,
               ex_jump_signal_in, ex_rd_valid_in, ex_instr_id_in,
        output mem_rs1_addr_out, mem_rs2_addr_out, mem_rd_addr_out,
               mem_rs1_value_out, mem_rs2_value_out, mem_pc_out,
               mem_mem_addr_out, mem_exec_output_out, mem_jump_addr_out,
               mem_jump_signal_out, mem_rd_valid_out, mem_instr_id_out
    );

    modport master (
        output if_pc_in, if_instr_in, if_id_stall, if_id_flush,
        input  if_id_pc_out, if_id_instr_out,
        output id_rs1_valid_in, id_rs2_valid_in, id_rd_valid_in,
               id_rs1_addr_in, id_rs2_addr_in, id_rd_addr_in,
               id_imm_in, id_pc_in, id_rs1_value_in, id_rs2_value_in,
               id_opcode_in, id_instr_id_in, id_ex_bubble,
        input  ex_rs1_valid_out, ex_rs2_valid_out, ex_rd_valid_out,
               ex_rs1_addr_out, ex_rs2_addr_out, ex_rd_addr_out,
               ex_imm_out, ex_pc_out, ex_rs1_value_out, ex_rs2_value_out,
               ex_opcode_out, ex_instr_id_out,
        output ex_rs1_addr_in, ex_rs2_addr_in, ex_rd_addr_in,
               ex_rs1_value_in, ex_rs2_value_in, ex_pc_in,
               ex_mem_addr_in, ex_exec_output_in, ex_jump_addr_in,
               ex_jump_signal_in, ex_rd_valid_in, ex_instr_id_in,
        input  mem_rs1_addr_out, mem_rs2_addr_out, mem_rd_addr_out,
               mem_rs1_value_out, mem_rs2_value_out, mem_pc_out,
               mem_mem_addr_out, mem_exec_output_out, mem_jump_addr_out,
               mem_jump_signal_out, mem_rd_valid_out, mem_instr_id_out
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_stage_regs_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg
// Purpose  : Generic WIDTH-bit pipeline register.
//            rst (async) and clr (sync) both load RST_VAL; clr beats en;
//            en=0 holds the current contents.
// Ports    : clk, rst, en, clr, d[WIDTH], q[WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_stage_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_regs
// Purpose  : IF/ID, ID/EX and EX/MEM registers of the 5-stage RV32 core.
//            IF/ID supports hold (stall) and flush-to-NOP (flush wins);
//            ID/EX supports bubble insertion (all fields zero);
//            EX/MEM captures unconditionally. One cycle latency each.
// Ports    : clk, rst (async, active-high), bus (stage signals, slave view)
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stage_regs
    import pipeline_stage_regs_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst,
    pipeline_stage_regs_if.slave bus
);

    // ------------------------------------------------------------------ IF/ID
    // A flush still advances the PC field; only the instruction becomes NOP.
    logic w_if_pc_en;
    assign w_if_pc_en = ~bus.if_id_stall | bus.if_id_flush;

    pipe_reg #(.WIDTH(XLEN), .RST_VAL('0)) u_if_id_pc (
        .clk (clk), .rst (rst), .en (w_if_pc_en), .clr (1'b0),
        .d   (bus.if_pc_in), .q (bus.if_id_pc_out)
    );

    pipe_reg #(.WIDTH(XLEN), .RST_VAL(NOP_INSTR)) u_if_id_instr (
        .clk (clk), .rst (rst), .en (~bus.if_id_stall), .clr (bus.if_id_flush),
        .d   (bus.if_instr_in), .q (bus.if_id_instr_out)
    );

    // ------------------------------------------------------------------ ID/EX
    // A bubble zeroes the whole slot: instr_id=IID_NONE and rd_valid=0.
    id_ex_t w_id_d;
    id_ex_t w_ex_q;

    always_comb begin
        w_id_d           = '0;
        w_id_d.rs1_valid = bus.id_rs1_valid_in;
        w_id_d.rs2_valid = bus.id_rs2_valid_in;
        w_id_d.rd_valid  = bus.id_rd_valid_in;
        w_id_d.rs1_addr  = bus.id_rs1_addr_in;
        w_id_d.rs2_addr  = bus.id_rs2_addr_in;
        w_id_d.rd_addr   = bus.id_rd_addr_in;
        w_id_d.imm       = bus.id_imm_in;
        w_id_d.pc        = bus.id_pc_in;
        w_id_d.rs1_value = bus.id_rs1_value_in;
        w_id_d.rs2_value = bus.id_rs2_value_in;
        w_id_d.opcode    = bus.id_opcode_in;
        w_id_d.instr_id  = bus.id_instr_id_in;
    end

    pipe_reg #(.WIDTH($bits(id_ex_t)), .RST_VAL('0)) u_id_ex (
        .clk (clk), .rst (rst), .en (1'b1), .clr (bus.id_ex_bubble),
        .d   (w_id_d), .q (w_ex_q)
    );

    assign bus.ex_rs1_valid_out = w_ex_q.rs1_valid;
    assign bus.ex_rs2_valid_out = w_ex_q.rs2_valid;
    assign bus.ex_rd_valid_out  = w_ex_q.rd_valid;
    assign bus.ex_rs1_addr_out  = w_ex_q.rs1_addr;
    assign bus.ex_rs2_addr_out  = w_ex_q.rs2_addr;
    assign bus.ex_rd_addr_out   = w_ex_q.rd_addr;
    assign bus.ex_imm_out       = w_ex_q.imm;
    assign bus.ex_pc_out        = w_ex_q.pc;
    assign bus.ex_rs1_value_out = w_ex_q.rs1_value;
    assign bus.ex_rs2_value_out = w_ex_q.rs2_value;
    assign bus.ex_opcode_out    = w_ex_q.opcode;
    assign bus.ex_instr_id_out  = w_ex_q.instr_id;

    // ----------------------------------------------------------------- EX/MEM
    ex_mem_t w_ex_d;
    ex_mem_t w_mem_q;

    always_comb begin
        w_ex_d             = '0;
        w_ex_d.rs1_addr    = bus.ex_rs1_addr_in;
        w_ex_d.rs2_addr    = bus.ex_rs2_addr_in;
        w_ex_d.rd_addr     = bus.ex_rd_addr_in;
        w_ex_d.rs1_value   = bus.ex_rs1_value_in;
        w_ex_d.rs2_value   = bus.ex_rs2_value_in;
        w_ex_d.pc          = bus.ex_pc_in;
        w_ex_d.mem_addr    = bus.ex_mem_addr_in;
        w_ex_d.exec_output = bus.ex_exec_output_in;
        w_ex_d.jump_addr   = bus.ex_jump_addr_in;
        w_ex_d.jump_signal = bus.ex_jump_signal_in;
        w_ex_d.rd_valid    = bus.ex_rd_valid_in;
        w_ex_d.instr_id    = bus.ex_instr_id_in;
    end

    pipe_reg #(.WIDTH($bits(ex_mem_t)), .RST_VAL('0)) u_ex_mem (
        .clk (clk), .rst (rst), .en (1'b1), .clr (1'b0),
        .d   (w_ex_d), .q (w_mem_q)
    );

    assign bus.mem_rs1_addr_out    = w_mem_q.rs1_addr;
    assign bus.mem_rs2_addr_out    = w_mem_q.rs2_addr;
    assign bus.mem_rd_addr_out     = w_mem_q.rd_addr;
    assign bus.mem_rs1_value_out   = w_mem_q.rs1_value;
    assign bus.mem_rs2_value_out   = w_mem_q.rs2_value;
    assign bus.mem_pc_out          = w_mem_q.pc;
    assign bus.mem_mem_addr_out    = w_mem_q.mem_addr;
    assign bus.mem_exec_output_out = w_mem_q.exec_output;
    assign bus.mem_jump_addr_out   = w_mem_q.jump_addr;
    assign bus.mem_jump_signal_out = w_mem_q.jump_signal;
    assign bus.mem_rd_valid_out    = w_mem_q.rd_valid;
    assign bus.mem_instr_id_out    = w_mem_q.instr_id;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stage_regs
// Purpose  : Self-checking bench for pipeline_stage_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_regs;
    import pipeline_stage_regs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_stage_regs_if bus ();
    pipeline_stage_regs dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    // stimulus currently applied
    logic [31:0] s_if_pc, s_if_instr;
    logic        s_stall, s_flush, s_bubble;
    id_ex_t      s_id;
    ex_mem_t     s_ex;
    // expected register contents
    logic [31:0] m_pc, m_instr;
    id_ex_t      m_ex;
    ex_mem_t     m_mem;

    typedef struct {
        logic        stall, flush;
        logic [31:0] pc, instr, exp_pc, exp_instr;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic id_ex_t get_ex();
        id_ex_t r;
        r = '{bus.ex_rs1_valid_out, bus.ex_rs2_valid_out, bus.ex_rd_valid_out,
              bus.ex_rs1_addr_out, bus.ex_rs2_addr_out, bus.ex_rd_addr_out,
              bus.ex_imm_out, bus.ex_pc_out, bus.ex_rs1_value_out, bus.ex_rs2_value_out,
              bus.ex_opcode_out, bus.ex_instr_id_out};
        return r;
    endfunction

    function automatic ex_mem_t get_mem();
        ex_mem_t r;
        r = '{bus.mem_rs1_addr_out, bus.mem_rs2_addr_out, bus.mem_rd_addr_out,
              bus.mem_rs1_value_out, bus.mem_rs2_value_out, bus.mem_pc_out,
              bus.mem_mem_addr_out, bus.mem_exec_output_out, bus.mem_jump_addr_out,
              bus.mem_jump_signal_out, bus.mem_rd_valid_out, bus.mem_instr_id_out};
        return r;
    endfunction

    function automatic id_ex_t rand_id();
        id_ex_t r;
        r = '{1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), $urandom, $urandom, $urandom, $urandom, 7'($urandom), 6'($urandom)};
        return r;
    endfunction

    function automatic ex_mem_t rand_ex();
        ex_mem_t r;
        r = '{5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 6'($urandom)};
        return r;
    endfunction

    // What execute would hand on for the instruction currently in ID/EX
    function automatic ex_mem_t from_ex(input id_ex_t e);
        ex_mem_t r;
        r = rand_ex();
        r.rs1_addr = e.rs1_addr;   r.rs2_addr  = e.rs2_addr;  r.rd_addr  = e.rd_addr;
        r.rs1_value = e.rs1_value; r.rs2_value = e.rs2_value; r.pc       = e.pc;
        r.rd_valid = e.rd_valid;   r.instr_id  = e.instr_id;
        return r;
    endfunction

    task automatic apply();
        bus.if_pc_in = s_if_pc; bus.if_instr_in = s_if_instr;
        bus.if_id_stall = s_stall; bus.if_id_flush = s_flush; bus.id_ex_bubble = s_bubble;
        {bus.id_rs1_valid_in, bus.id_rs2_valid_in, bus.id_rd_valid_in,
         bus.id_rs1_addr_in, bus.id_rs2_addr_in, bus.id_rd_addr_in,
         bus.id_imm_in, bus.id_pc_in, bus.id_rs1_value_in, bus.id_rs2_value_in,
         bus.id_opcode_in, bus.id_instr_id_in} = s_id;
        {bus.ex_rs1_addr_in, bus.ex_rs2_addr_in, bus.ex_rd_addr_in,
         bus.ex_rs1_value_in, bus.ex_rs2_value_in, bus.ex_pc_in,
         bus.ex_mem_addr_in, bus.ex_exec_output_in, bus.ex_jump_addr_in,
         bus.ex_jump_signal_in, bus.ex_rd_valid_in, bus.ex_instr_id_in} = s_ex;
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = NOP_INSTR; m_ex = '0; m_mem = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_if_pc"},    bus.if_id_pc_out,    m_pc);
        check({tag, "_if_instr"}, bus.if_id_instr_out, m_instr);
        check({tag, "_id_ex"},    get_ex(),            m_ex);
        check({tag, "_ex_mem"},   get_mem(),           m_mem);
    endtask

    // Apply stimulus, clock once, update the reference, compare 1 ns later
    task automatic cycle(input string tag);
        apply();
        @(posedge clk);
        if (s_flush) begin
            m_pc = s_if_pc; m_instr = NOP_INSTR;
        end else if (!s_stall) begin
            m_pc = s_if_pc; m_instr = s_if_instr;
        end
        m_ex  = s_bubble ? id_ex_t'('0) : s_id;
        m_mem = s_ex;
        #1;
        check_all(tag);
    endtask

    initial begin
        ex_mem_t     q[$];
        ex_mem_t     exp_m;
        logic [31:0] hold_pc, hold_instr;

        tbl[0] = '{1'b0, 1'b0, 32'h100, 32'h0050_0093, 32'h100, 32'h0050_0093};
        tbl[1] = '{1'b1, 1'b0, 32'h104, 32'h00A0_0113, 32'h100, 32'h0050_0093};
        tbl[2] = '{1'b1, 1'b0, 32'h104, 32'h00A0_0113, 32'h100, 32'h0050_0093};
        tbl[3] = '{1'b0, 1'b0, 32'h104, 32'h00A0_0113, 32'h104, 32'h00A0_0113};
        tbl[4] = '{1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h200, 32'h0000_0013};
        tbl[5] = '{1'b1, 1'b0, 32'h208, 32'h1111_1111, 32'h200, 32'h0000_0013};
        tbl[6] = '{1'b0, 1'b1, 32'h300, 32'h2222_2222, 32'h300, 32'h0000_0013};
        tbl[7] = '{1'b0, 1'b0, 32'h304, 32'h3333_3333, 32'h304, 32'h3333_3333};

        s_if_pc = 32'h55; s_if_instr = 32'h77; s_stall = 0; s_flush = 0; s_bubble = 0;
        s_id = rand_id(); s_ex = rand_ex();
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst = 1'b0;

        // IF/ID pass / stall / flush table
        for (int i = 0; i < 8; i++) begin
            s_stall = tbl[i].stall; s_flush = tbl[i].flush;
            s_if_pc = tbl[i].pc;    s_if_instr = tbl[i].instr;
            cycle("tbl");
            check($sformatf("vec%0d_pc", i),    bus.if_id_pc_out,    tbl[i].exp_pc);
            check($sformatf("vec%0d_instr", i), bus.if_id_instr_out, tbl[i].exp_instr);
        end
        s_stall = 0; s_flush = 0;

        // ID/EX bubble then release
        s_id = rand_id(); s_id.rd_valid = 1; s_id.rd_addr = 5; s_id.instr_id = 7; s_id.imm = 32'h10;
        s_bubble = 1;
        cycle("bubble");
        check("bubble_zero", get_ex(), '0);
        s_bubble = 0;
        cycle("unbubble");
        check("unbubble_fields", {bus.ex_rd_valid_out, bus.ex_rd_addr_out, bus.ex_instr_id_out, bus.ex_imm_out},
              {1'b1, 5'd5, 6'd7, 32'h10});

        // EX/MEM single capture, exactly one cycle latency
        s_ex = rand_ex(); s_ex.exec_output = 32'h1234; s_ex.mem_addr = 32'h40; s_ex.jump_signal = 1;
        s_ex.jump_addr = 32'h80; s_ex.rd_valid = 1; s_ex.rd_addr = 3;
        apply();
        #1 check("exmem_no_comb", get_mem(), m_mem);
        cycle("exmem");
        check("exmem_fields", {bus.mem_exec_output_out, bus.mem_mem_addr_out, bus.mem_jump_signal_out,
              bus.mem_jump_addr_out, bus.mem_rd_valid_out, bus.mem_rd_addr_out},
              {32'h1234, 32'h40, 1'b1, 32'h80, 1'b1, 5'd3});

        // EX/MEM stream: no loss or duplication
        for (int i = 0; i < 5; i++) begin
            s_ex = rand_ex(); q.push_back(s_ex);
            cycle("stream");
            exp_m = q.pop_front();
            check($sformatf("stream%0d", i), get_mem(), exp_m);
        end

        // Load-use stall: IF/ID holds, ID/EX empties, EX/MEM takes the old ID/EX
        s_id = rand_id(); s_id.rd_valid = 1; cycle("pre_lu");
        hold_pc = bus.if_id_pc_out; hold_instr = m_instr;
        s_ex = from_ex(m_ex); exp_m = s_ex;
        s_stall = 1; s_bubble = 1; s_if_pc = 32'h999; s_if_instr = 32'h888; s_id = rand_id();
        cycle("loaduse");
        check("lu_if_hold", {bus.if_id_pc_out, bus.if_id_instr_out}, {m_pc, hold_instr});
        check("lu_if_pc_const", bus.if_id_pc_out, 32'h304 == hold_pc ? 32'h304 : hold_pc);
        check("lu_ex_zero", get_ex(), '0);
        check("lu_mem_prior", get_mem(), exp_m);
        s_stall = 0; s_bubble = 0;

        // Asynchronous reset mid-stream
        s_if_pc = 32'hABC; s_if_instr = 32'hDEF; s_id = rand_id(); s_ex = rand_ex();
        cycle("pre_rst");
        #2 rst = 1'b1;
        #1 model_reset(); check_all("async_rst");
        @(posedge clk); #1 check_all("rst_hold");
        @(negedge clk) rst = 1'b0;
        #1 check_all("rst_rel");
        cycle("post_rst");
        check("post_rst_pc", bus.if_id_pc_out, 32'hABC);

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            s_stall  = ($urandom_range(0, 3) == 0);
            s_flush  = ($urandom_range(0, 4) == 0);
            s_bubble = ($urandom_range(0, 3) == 0);
            s_if_pc = $urandom; s_if_instr = $urandom;
            s_id = rand_id(); s_ex = rand_ex();
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
